serial_parity: RTL and testbench



---
 rtl/parity_pkg.sv | 30 +++
 rtl/parity_frame_ctr.sv | 35 +++
 rtl/serial_parity.sv | 82 ++++++++
 tb/tb_serial_parity.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// ---------------------------------------------------------------------------
// parity_pkg
// Shared definitions for the serial parity tracker:
//   par_state_t      - 1-flop parity state (PAR_EVEN = XOR 0, PAR_ODD = XOR 1)
//   DEF_FRAME_LEN    - default frame length (0 = unbounded running parity)
//   DEF_CNT_W        - default width of the frame bit counter
//   par_step()       - next parity state for one sampled bit
// ---------------------------------------------------------------------------
package parity_pkg;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } par_state_t;

  localparam int DEF_FRAME_LEN = 0;
  localparam int DEF_CNT_W     = 16;

  // A 1 bit toggles the accumulated parity, a 0 bit leaves it alone.
  function automatic par_state_t par_step(input par_state_t cur, input logic bit_in);
    par_state_t nxt;
    case (cur)
      PAR_EVEN: nxt = bit_in ? PAR_ODD : PAR_EVEN;
      PAR_ODD:  nxt = bit_in ? PAR_EVEN : PAR_ODD;
      default:  nxt = PAR_EVEN;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/parity_frame_ctr.sv
// ---------------------------------------------------------------------------
// parity_frame_ctr
// Counts sampled bits within a frame and flags the last bit of each frame.
// Ports:
//   clock - system clock, rising edge
//   reset - synchronous active-high reset, clears the count
//   tc    - high while the bit being sampled on the next edge is the
//           FRAME_LEN-th bit of the current frame
// ---------------------------------------------------------------------------
module parity_frame_ctr #(
  parameter int FRAME_LEN = 4,
  parameter int CNT_W     = 16
) (
  input  logic clock,
  input  logic reset,
  output logic tc
);

  logic [CNT_W-1:0] cnt_r;

  // Terminal count is decoded from the register, so it is glitch-free at the edge.
  assign tc = (cnt_r == CNT_W'(FRAME_LEN - 1));

  // Bit counter: wraps to zero on the last bit so frames run back to back.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (tc) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

endmodule

// File: rtl/serial_parity.sv
// ---------------------------------------------------------------------------
// serial_parity
// Moore FSM tracking the running XOR of a serial bit stream, with optional
// fixed-length framing that restarts accumulation every FRAME_LEN bits.
// Ports:
//   clock        - system clock, rising edge
//   reset        - synchronous active-high reset
//   in           - serial data bit, sampled every rising edge
//   out          - registered running parity (inverted when ODD_MODE = 1)
//   frame_done   - one-cycle pulse after the last bit of a frame (0 if unframed)
//   frame_parity - parity of the last completed frame, held until the next one
// ---------------------------------------------------------------------------
module serial_parity
  import parity_pkg::*;
#(
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int ODD_MODE  = 0,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic clock,
  input  logic reset,
  input  logic in,
  output logic out,
  output logic frame_done,
  output logic frame_parity
);

  localparam logic ODD_BIT = (ODD_MODE != 0) ? 1'b1 : 1'b0;

  par_state_t state_r;
  par_state_t state_nxt_s;
  logic       out_r;
  logic       done_r;
  logic       fparity_r;
  logic       tc_s;

  generate
    if (FRAME_LEN > 0) begin : g_framed
      parity_frame_ctr #(
        .FRAME_LEN (FRAME_LEN),
        .CNT_W     (CNT_W)
      ) u_ctr (
        .clock (clock),
        .reset (reset),
        .tc    (tc_s)
      );
    end else begin : g_unframed
      assign tc_s = 1'b0;
    end
  endgenerate

  // Parity including the bit sampled on the coming edge.
  always_comb begin
    state_nxt_s = par_step(state_r, in);
  end

  // State and output registers; the last bit of a frame reports the frame
  // parity and clears the accumulator so the next bit opens a new frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= PAR_EVEN;
      out_r     <= ODD_BIT;
      done_r    <= 1'b0;
      fparity_r <= ODD_BIT;
    end else if (tc_s) begin
      state_r   <= PAR_EVEN;
      out_r     <= ODD_BIT;
      done_r    <= 1'b1;
      fparity_r <= (state_nxt_s == PAR_ODD) ^ ODD_BIT;
    end else begin
      state_r   <= state_nxt_s;
      out_r     <= (state_nxt_s == PAR_ODD) ^ ODD_BIT;
      done_r    <= 1'b0;
      fparity_r <= fparity_r;
    end
  end

  assign out          = out_r;
  assign frame_done   = done_r;
  assign frame_parity = fparity_r;

endmodule

// File: tb/tb_serial_parity.sv
// ---------------------------------------------------------------------------
// tb_serial_parity
// Drives one shared stimulus into five configurations of serial_parity and
// compares every output against a hand-computed vector table.
//   u_r0  : FRAME_LEN=0, ODD_MODE=0   u_r1  : FRAME_LEN=0, ODD_MODE=1
//   u_f4  : FRAME_LEN=4, ODD_MODE=0   u_f4o : FRAME_LEN=4, ODD_MODE=1
//   u_f1  : FRAME_LEN=1, ODD_MODE=0
// ---------------------------------------------------------------------------
module tb_serial_parity;

  logic clock;
  logic reset;
  logic din;

  logic r0_out, r0_done, r0_fp;
  logic r1_out, r1_done, r1_fp;
  logic f4_out, f4_done, f4_fp;
  logic f4o_out, f4o_done, f4o_fp;
  logic f1_out, f1_done, f1_fp;

  int checks;
  int failures;

  serial_parity #(.FRAME_LEN(0), .ODD_MODE(0), .CNT_W(16)) u_r0 (
    .clock(clock), .reset(reset), .in(din),
    .out(r0_out), .frame_done(r0_done), .frame_parity(r0_fp));
  serial_parity #(.FRAME_LEN(0), .ODD_MODE(1), .CNT_W(16)) u_r1 (
    .clock(clock), .reset(reset), .in(din),
    .out(r1_out), .frame_done(r1_done), .frame_parity(r1_fp));
  serial_parity #(.FRAME_LEN(4), .ODD_MODE(0), .CNT_W(16)) u_f4 (
    .clock(clock), .reset(reset), .in(din),
    .out(f4_out), .frame_done(f4_done), .frame_parity(f4_fp));
  serial_parity #(.FRAME_LEN(4), .ODD_MODE(1), .CNT_W(3)) u_f4o (
    .clock(clock), .reset(reset), .in(din),
    .out(f4o_out), .frame_done(f4o_done), .frame_parity(f4o_fp));
  serial_parity #(.FRAME_LEN(1), .ODD_MODE(0), .CNT_W(16)) u_f1 (
    .clock(clock), .reset(reset), .in(din),
    .out(f1_out), .frame_done(f1_done), .frame_parity(f1_fp));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One record per clock edge: inputs, then expected outputs after that edge.
  // e0/e1 = running parity out (ODD_MODE 0/1); e4* = FRAME_LEN 4; f1* = FRAME_LEN 1
  typedef struct packed {
    logic rst;
    logic din;
    logic e0;
    logic e1;
    logic e4o;
    logic e4d;
    logic e4f;
    logic f1o;
    logic f1d;
    logic f1f;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int idx, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%b expected=%b", name, idx, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic d);
    @(negedge clock);
    reset = r;
    din   = d;
    @(posedge clock);
    #1;
  endtask

  initial begin
    int pulses;
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    din      = 1'b0;

    //                          r d e0 e1 f4:o d f  f1:o d f
    // reset for 2 edges (in=1 on the second is discarded), then idle 4 edges
    vecs.push_back(vec_t'(10'b1_0_0_1_000_000));
    vecs.push_back(vec_t'(10'b1_1_0_1_000_000));
    vecs.push_back(vec_t'(10'b0_0_0_1_000_010));
    vecs.push_back(vec_t'(10'b0_0_0_1_000_010));
    vecs.push_back(vec_t'(10'b0_0_0_1_000_010));
    vecs.push_back(vec_t'(10'b0_0_0_1_010_010));
    // running parity stream 0,0,1,1,0,1,1,0,1
    vecs.push_back(vec_t'(10'b1_0_0_1_000_000));
    vecs.push_back(vec_t'(10'b0_0_0_1_000_010));
    vecs.push_back(vec_t'(10'b0_0_0_1_000_010));
    vecs.push_back(vec_t'(10'b0_1_1_0_100_011));
    vecs.push_back(vec_t'(10'b0_1_0_1_010_011));
    vecs.push_back(vec_t'(10'b0_0_0_1_000_010));
    vecs.push_back(vec_t'(10'b0_1_1_0_100_011));
    vecs.push_back(vec_t'(10'b0_1_0_1_000_011));
    vecs.push_back(vec_t'(10'b0_0_0_1_010_010));
    vecs.push_back(vec_t'(10'b0_1_1_0_100_011));
    // mid-stream reset: 1,1,1 then reset with in=1, then 1
    vecs.push_back(vec_t'(10'b1_0_0_1_000_000));
    vecs.push_back(vec_t'(10'b0_1_1_0_100_011));
    vecs.push_back(vec_t'(10'b0_1_0_1_000_011));
    vecs.push_back(vec_t'(10'b0_1_1_0_100_011));
    vecs.push_back(vec_t'(10'b1_1_0_1_000_000));
    vecs.push_back(vec_t'(10'b0_1_1_0_100_011));
    // framing: 1,0,1,1 | 0,1,0,0
    vecs.push_back(vec_t'(10'b1_0_0_1_000_000));
    vecs.push_back(vec_t'(10'b0_1_1_0_100_011));
    vecs.push_back(vec_t'(10'b0_0_1_0_100_010));
    vecs.push_back(vec_t'(10'b0_1_0_1_000_011));
    vecs.push_back(vec_t'(10'b0_1_1_0_011_011));
    vecs.push_back(vec_t'(10'b0_0_1_0_001_010));
    vecs.push_back(vec_t'(10'b0_1_0_1_101_011));
    vecs.push_back(vec_t'(10'b0_0_0_1_101_010));
    vecs.push_back(vec_t'(10'b0_0_0_1_011_010));
    // partial frame 1,1 abandoned by reset, then full frame 1,1,1,0 and one more bit
    vecs.push_back(vec_t'(10'b0_1_1_0_101_011));
    vecs.push_back(vec_t'(10'b0_1_0_1_001_011));
    vecs.push_back(vec_t'(10'b1_0_0_1_000_000));
    vecs.push_back(vec_t'(10'b0_1_1_0_100_011));
    vecs.push_back(vec_t'(10'b0_1_0_1_000_011));
    vecs.push_back(vec_t'(10'b0_1_1_0_100_011));
    vecs.push_back(vec_t'(10'b0_0_1_0_011_010));
    vecs.push_back(vec_t'(10'b0_0_1_0_001_010));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].din);
      check("r0_out",       i, r0_out,   vecs[i].e0);
      check("r0_done",      i, r0_done,  1'b0);
      check("r1_out",       i, r1_out,   vecs[i].e1);
      check("r1_done",      i, r1_done,  1'b0);
      check("f4_out",       i, f4_out,   vecs[i].e4o);
      check("f4_done",      i, f4_done,  vecs[i].e4d);
      check("f4_parity",    i, f4_fp,    vecs[i].e4f);
      check("f4odd_out",    i, f4o_out,  ~vecs[i].e4o);
      check("f4odd_done",   i, f4o_done, vecs[i].e4d);
      check("f4odd_parity", i, f4o_fp,   ~vecs[i].e4f);
      check("f1_out",       i, f1_out,   vecs[i].f1o);
      check("f1_done",      i, f1_done,  vecs[i].f1d);
      check("f1_parity",    i, f1_fp,    vecs[i].f1f);
    end

    // Back-to-back frames of all ones: exactly two single-cycle pulses in 8 edges,
    // each even parity; the running trackers end at even parity as well.
    step(1'b1, 1'b0);
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b1);
      if (f4_done === 1'b1) pulses++;
    end
    check("b2b_pulses", 0, (pulses == 2) ? 1'b1 : 1'b0, 1'b1);
    check("b2b_done",   0, f4_done, 1'b1);
    check("b2b_parity", 0, f4_fp,   1'b0);
    check("b2b_out",    0, f4_out,  1'b0);
    check("b2b_r0_out", 0, r0_out,  1'b0);
    step(1'b0, 1'b1);
    check("b2b_drop",   0, f4_done, 1'b0);
    check("b2b_hold",   0, f4_fp,   1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
